fifo_rd_arbiter: RTL and testbench
==================================

// Module: fifo_rd_arbiter
// PURPOSE
//  Shares the async FIFO read port (rd_clk domain) between NUM_REQ consumers.
//  - Drives rd_inc into the read-pointer/empty logic and sees rd_empty from it.
//  - Grants the port round-robin in bursts of up to BURST_LEN pops.
//  - Presents each popped word on a 1-deep registered output tagged with the owner id.
//  - Sits between the FIFO read side and the downstream consumers.
// PARAMETERS
//  NUM_REQ    4  number of consumers (>=2)
//  DATA_SIZE  8  FIFO word width
//  BURST_LEN  4  max pops per grant (>=1)
//  ID_W       $clog2(NUM_REQ)  localparam, owner id width
// PORTS
//  rd_clk     in   1          read-domain clock
//  rd_rst     in   1          asynchronous, active-high reset
//  rd_empty   in   1          FIFO empty flag (registered, rd_clk domain)
//  rd_data    in   DATA_SIZE  FIFO read data at current rd_addr (valid when !rd_empty)
//  rd_inc     out  1          pop strobe to FIFO read logic
//  req        in   NUM_REQ    consumer i wants data (level)
//  out_ready  in   NUM_REQ    consumer i accepts out_data this cycle
//  gnt        out  NUM_REQ    one-hot current owner (0 when idle)
//  out_valid  out  1          out_data/out_id hold a word
//  out_data   out  DATA_SIZE  popped word
//  out_id     out  ID_W       owner the word belongs to
// BEHAVIOUR
//  - Reset, async on rd_rst high: state=IDLE, gnt=0, rd_inc=0, out_valid=0, out_data=0,
//    out_id=0, rr pointer=0, burst cnt=0. Mid-operation reset drops the held word;
//    no pop is issued while rd_rst is high.
//  - FSM IDLE: if |req && !rd_empty -> GRANT. Owner = first requester at or after rr_ptr,
//    searching upward with wrap. gnt is registered, so gnt rises 1 cycle after req.
//  - FSM GRANT:
//    - rd_inc = !rd_empty && req[owner] && (!out_valid || out_ready[out_id]) && cnt<BURST_LEN.
//    - Each pop: out_data<=rd_data, out_id<=owner, out_valid<=1, cnt++.
//    - out_valid clears on out_ready[out_id] with no same-cycle pop.
//    - Pop plus accept in the same cycle: new word replaces the old, out_valid stays 1.
//  - Latency: req@n (FIFO non-empty) -> gnt@n+1, first rd_inc@n+1, out_valid@n+2.
//    Throughput is 1 word/cycle while out_ready is held.
//  - GRANT -> RELEASE when: cnt==BURST_LEN, or req[owner]==0, or rd_empty sampled high
//    while owner has no pending pop.
//  - RELEASE: gnt=0, rd_inc=0. rr_ptr <= owner+1, mod NUM_REQ, wrapping NUM_REQ-1 -> 0.
//    cnt <= 0. Next state IDLE, giving 1 dead cycle between grants.
//  - The word already in out_data stays valid across RELEASE/IDLE until accepted by its
//    out_id owner. A new owner cannot pop until that word is accepted, so no overwrite.
//  - rd_empty high: rd_inc is never asserted (no underflow), and the FSM never enters GRANT.
//  - cnt is $clog2(BURST_LEN+1) bits wide. rr_ptr is ID_W bits wide; its wrap is explicit,
//    not reliant on overflow.
// CONFIGURATION
//  FIFO_RD_ARB_PRIO0_EN defined:
//    - Requester 0 wins every IDLE arbitration it requests, regardless of rr_ptr.
//    - It still cannot preempt a burst in progress.
//    - When 0 is not requesting, the others arbitrate round-robin as normal.
//  Undefined: pure round-robin as above.
// STRUCTURE
//  - Package fifo_arb_pkg: typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_RELEASE}
//    arb_state_t; function id_w(n)=$clog2(n).
//  - Sub-module rr_pick #(N): combinational. Inputs req[N], ptr[$clog2(N)].
//    Outputs one-hot gnt[N], idx, any. Instantiated once.
// TESTING
//  1. req=4'b0001, FIFO holds 3 words, out_ready=1 -> gnt=0001 @+1, 3 pops; rd_empty
//     -> RELEASE; out_id=0 x3; rr_ptr=1.
//  2. req=4'b1111, FIFO 16 words, BURST_LEN=4 -> owners 0,1,2,3 in turn, 4 pops each,
//     1 dead cycle between bursts, data in FIFO order.
//  3. Owner 2 drops out_ready for 5 cycles mid-burst -> rd_inc=0, out_valid/out_data held;
//     resumes with no loss or duplication.
//  4. rd_empty=1 with req=4'b1010 -> rd_inc never 1, gnt stays 0. Write 1 word ->
//     owner 1 gets it, then owner 3 is next.
//  5. rd_rst pulsed high mid-burst with out_valid=1 -> all outputs 0 asynchronously;
//     after release, arbitration restarts from requester 0.
//  6. With FIFO_RD_ARB_PRIO0_EN defined: req=4'b1111, rr_ptr=2 -> owner 0 wins;
//     without it, owner 2 wins.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: arbiter state encoding and id-width helper shared by fifo_rd_arbiter and rr_pick
package fifo_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_RELEASE} arb_state_t;
  function automatic int id_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester at or above ptr with wrap
module rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [W-1:0] w_j;
  always_comb begin
    idx = '0;
    w_j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = W'((int'(ptr) + k) % N);
      if (req[w_j]) idx = w_j;
    end
  end
  assign any = |req;
  assign gnt = any ? N'(1) << idx : '0;
endmodule

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin burst arbiter for the async FIFO read port with a 1-deep tagged output; FIFO_RD_ARB_PRIO0_EN gives requester 0 priority at arbitration
module fifo_rd_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int BURST_LEN = 4,
  localparam int ID_W     = id_w(NUM_REQ)
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic                 rd_empty,
  input  logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_inc,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   out_ready,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data,
  output logic [ID_W-1:0]      out_id
);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
  arb_state_t r_state, w_state_nxt;
  logic [ID_W-1:0] r_owner, r_rr_ptr, w_pick_ptr, w_pick_idx;
  logic [NUM_REQ-1:0] r_gnt, w_pick_gnt;
  logic [CNT_W-1:0] r_cnt;
  logic r_out_valid, w_pick_any, w_end;
  logic [DATA_SIZE-1:0] r_out_data;
  logic [ID_W-1:0] r_out_id;
`ifdef FIFO_RD_ARB_PRIO0_EN
  assign w_pick_ptr = req[0] ? '0 : r_rr_ptr;
`else
  assign w_pick_ptr = r_rr_ptr;
`endif
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req(req),
    .ptr(w_pick_ptr),
    .gnt(w_pick_gnt),
    .idx(w_pick_idx),
    .any(w_pick_any)
  );
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) r_state <= ARB_IDLE;
    else r_state <= w_state_nxt;
  end
  // the burst ends on the cycle of its last pop so the dead time stays short
  always_comb begin
    w_end = (r_cnt + CNT_W'(rd_inc)) == BURST_MAX || !req[r_owner] || rd_empty;
    w_state_nxt = ARB_IDLE;
    if (r_state == ARB_IDLE && w_pick_any && !rd_empty) w_state_nxt = ARB_GRANT;
    if (r_state == ARB_GRANT) w_state_nxt = w_end ? ARB_RELEASE : ARB_GRANT;
  end
  always_comb begin
    gnt = r_state == ARB_GRANT ? r_gnt : '0;
    rd_inc = r_state == ARB_GRANT && !rd_empty && req[r_owner] &&
             (!r_out_valid || out_ready[r_out_id]) && r_cnt < BURST_MAX;
  end
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_owner     <= '0;
      r_gnt       <= '0;
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
    end else begin
      if (r_state == ARB_IDLE && w_state_nxt == ARB_GRANT) begin
        r_owner <= w_pick_idx;
        r_gnt   <= w_pick_gnt;
      end
      if (r_state == ARB_RELEASE) begin
        r_rr_ptr <= r_owner == LAST_ID ? '0 : r_owner + 1'b1;
        r_cnt    <= '0;
      end else if (rd_inc) r_cnt <= r_cnt + 1'b1;
      if (rd_inc) begin
        r_out_valid <= 1'b1;
        r_out_data  <= rd_data;
        r_out_id    <= r_owner;
      end else if (r_out_valid && out_ready[r_out_id]) r_out_valid <= 1'b0;
    end
  end
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: directed scenarios plus random traffic against a behavioural burst/round-robin model
module tb_fifo_rd_arbiter;
  localparam int N = 4, DW = 8, BL = 4;
  logic rd_clk = 1'b0, rd_rst = 1'b0, rd_empty = 1'b1, rd_inc, out_valid;
  logic [DW-1:0] rd_data = '0, out_data;
  logic [N-1:0] req = '0, out_ready = '0, gnt;
  logic [1:0] out_id;
  always #5 rd_clk = ~rd_clk;
  fifo_rd_arbiter #(.NUM_REQ(N), .DATA_SIZE(DW), .BURST_LEN(BL)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_empty(rd_empty), .rd_data(rd_data),
    .rd_inc(rd_inc), .req(req), .out_ready(out_ready), .gnt(gnt),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id)
  );
  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] fifo[$];
  logic [DW-1:0] wdat = '0;
  int pend = 0;
  logic [N-1:0] t_req = '0, t_ready = '0;
  int m_ph = 0, m_own = 0, m_ptr = 0, m_cnt = 0, m_id = 0;
  logic m_v = 1'b0;
  logic [DW-1:0] m_d = '0;
  logic [N-1:0] s_gnt;
  logic s_inc, s_v;
  logic [DW-1:0] s_d;
  logic [1:0] s_id;
  int acc_cnt[N];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef FIFO_RD_ARB_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction
  // one rd_clk cycle: drive at negedge, sample and compare 1ns later, advance the model
  task automatic cycle();
    logic e_pop, emp;
    logic [N-1:0] e_gnt;
    @(negedge rd_clk);
    repeat (pend) begin
      fifo.push_back(wdat);
      wdat++;
    end
    pend = 0;
    req = t_req;
    out_ready = t_ready;
    emp = fifo.size() == 0;
    rd_empty = emp;
    rd_data = emp ? '0 : fifo[0];
    #1;
    s_gnt = gnt; s_inc = rd_inc; s_v = out_valid; s_d = out_data; s_id = out_id;
    e_gnt = m_ph == 1 ? N'(1) << m_own : '0;
    e_pop = m_ph == 1 && !emp && t_req[m_own] && (!m_v || t_ready[m_id]) && m_cnt < BL;
    chk("gnt", s_gnt, e_gnt);
    chk("rd_inc", s_inc, e_pop);
    chk("out_valid", s_v, m_v);
    chk("out_data", s_d, m_d);
    chk("out_id", s_id, m_id);
    chk("underflow", s_inc & emp, 0);
    if (s_v && t_ready[s_id]) acc_cnt[s_id]++;
    if (e_pop) begin
      m_d = fifo.pop_front();
      m_v = 1'b1;
      m_id = m_own;
      m_cnt++;
    end else if (m_v && t_ready[m_id]) m_v = 1'b0;
    case (m_ph)
      0: if (|t_req && !emp) begin m_own = pick(t_req, m_ptr); m_ph = 1; end
      1: if (m_cnt == BL || !t_req[m_own] || emp) m_ph = 2;
      default: begin m_ph = 0; m_ptr = (m_own + 1) % N; m_cnt = 0; end
    endcase
  endtask
  task automatic run(input int n);
    repeat (n) cycle();
  endtask
  task automatic wait_gnt(input int lim, output logic [N-1:0] g);
    g = '0;
    for (int i = 0; i < lim && g == '0; i++) begin
      cycle();
      g = s_gnt;
    end
    if (g == '0) begin
      n_chk++; n_fail++;
      $display("FAIL wait_gnt: no grant within %0d cycles", lim);
    end
  endtask
  task automatic do_reset();
    @(negedge rd_clk);
    t_req = '0; req = '0; out_ready = '0;
    #2 rd_rst = 1'b1;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_rd_inc", rd_inc, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_id, 0);
    @(negedge rd_clk);
    rd_rst = 1'b0;
    m_ph = 0; m_own = 0; m_ptr = 0; m_cnt = 0; m_id = 0; m_v = 1'b0; m_d = '0;
  endtask
  initial begin
    logic [N-1:0] g;
    logic [DW-1:0] base, hd;
    int np, na, a0, ow;
    do_reset();
    // single requester, 3 words, ends on empty
    t_ready = '1; t_req = 4'b0001; pend = 3; np = 0; na = 0;
    cycle(); np += int'(s_inc);
    cycle(); np += int'(s_inc);
    chk("t1_gnt", s_gnt, 4'b0001);
    chk("t1_first_inc", s_inc, 1);
    cycle(); np += int'(s_inc);
    chk("t1_valid_latency", s_v, 1);
    chk("t1_id", s_id, 0);
    for (int i = 0; i < 8; i++) begin cycle(); np += int'(s_inc); end
    chk("t1_pops", np, 3);
    chk("t1_acc0", acc_cnt[0], 3);
    // all requesting, 16 words: bursts of 4 rotating from requester 1
    t_req = '1; base = wdat; pend = 16; np = 0; na = 0;
    for (int i = 0; i < 80 && (np < 16 || na < 16); i++) begin
      cycle();
      if (s_inc) begin
        ow = $clog2(s_gnt);
        chk("t2_owner", ow, (1 + np / 4) % 4);
        np++;
      end
      if (s_v && t_ready[s_id]) begin
        chk("t2_data", s_d, DW'(base + na));
        na++;
      end
    end
    chk("t2_pops", np, 16);
    chk("t2_accepts", na, 16);
    // owner 2 stalls mid-burst
    t_req = 4'b0100; pend = 8; np = 0; a0 = acc_cnt[2];
    for (int i = 0; i < 30 && np < 2; i++) begin cycle(); np += int'(s_inc); end
    t_ready = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t3_stall_inc", s_inc, 0);
      chk("t3_stall_valid", s_v, 1);
      if (i == 0) hd = s_d;
      else chk("t3_hold", s_d, hd);
    end
    t_ready = '1;
    run(40);
    chk("t3_words", acc_cnt[2] - a0, 8);
    // empty FIFO blocks arbitration
    do_reset();
    t_ready = '1; t_req = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_idle_gnt", s_gnt, 0);
      chk("t4_idle_inc", s_inc, 0);
    end
    pend = 1;
    wait_gnt(10, g);
    chk("t4_first_owner", g, 4'b0010);
    run(6);
    pend = 1;
    wait_gnt(10, g);
    chk("t4_second_owner", g, 4'b1000);
    run(6);
    // reset mid-burst, then restart from requester 0
    t_req = '1; pend = 8;
    for (int i = 0; i < 20 && !(s_v && s_gnt != '0); i++) cycle();
    chk("t5_midburst", s_v && s_gnt != '0, 1);
    do_reset();
    t_req = '1; t_ready = '1;
    wait_gnt(10, g);
    chk("t5_restart_owner", g, 4'b0001);
    run(40);
    // arbitration with rr pointer at 2
    do_reset();
    t_ready = '1; t_req = 4'b0010; pend = 1;
    run(8);
    t_req = '1; pend = 4;
    wait_gnt(10, g);
`ifdef FIFO_RD_ARB_PRIO0_EN
    chk("t6_owner", g, 4'b0001);
`else
    chk("t6_owner", g, 4'b0100);
`endif
    run(20);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      t_req = N'($urandom);
      t_ready = ($urandom % 4 == 0) ? N'($urandom) : '1;
      if (fifo.size() < 12 && $urandom % 3 != 0) pend = $urandom_range(0, 2);
      cycle();
    end
    t_req = '1; t_ready = '1;
    run(100);
    chk("drain_empty", fifo.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
